instruction_fetch_unit: RTL

Instruction-fetch (IF) stage for the pipelined CPU: owns the program counter, drives the byte address into the instruction ROM, and captures the returned word into the IF/ID pipeline register. It honours hazard freeze, flush and branch redirect from later stages. It detects the program-terminating jump-to-self and parks the front end until reset or a redirect.

---
 rtl/instruction_fetch_unit_pkg.sv | 23 ++
 rtl/instruction_fetch_unit_if.sv | 28 ++
 rtl/instruction_fetch_unit_if_id_register.sv | 45 ++++
 rtl/instruction_fetch_unit.sv | 114 +++++++++++
 4 files changed

// File: rtl/instruction_fetch_unit_pkg.sv
// Shared CPU definitions for the fetch stage: opcodes, the NOP word, the PC step and the
// fetch FSM state type.
package instruction_fetch_unit_pkg;

   localparam logic [5:0]  HALT_OPCODE = 6'b101010;
   localparam logic [5:0]  BEZ_OPCODE  = 6'b101000;
   localparam logic [5:0]  BNE_OPCODE  = 6'b101001;

   localparam logic [31:0] NOP_WORD    = 32'd0;
   localparam logic [31:0] PC_STEP     = 32'd4;

   typedef enum logic [1:0] {
      StBoot,
      StRun,
      StHalt
   } fetch_state_e;

   // Jump-to-self: unconditional jump opcode with an all-ones offset field.
   function automatic logic is_halt_word(input logic [31:0] instr, input logic [5:0] opcode);
      return (instr[31:26] == opcode) && (instr[15:0] == 16'hFFFF);
   endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Bundle of the fetch stage's pipeline-control, ROM and IF/ID-output signals.
//   slave  : the fetch unit (consumes control + ROM data, drives ROM address + IF/ID).
//   master : the surrounding pipeline / ROM / testbench.
interface instruction_fetch_unit_if;

   logic        freeze;
   logic        flush;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic [31:0] rom_address;
   logic [31:0] rom_instruction;
   logic [31:0] if_pc;
   logic [31:0] if_instruction;
   logic        if_valid;
   logic        halted;
   logic [15:0] fetch_count;

   modport slave (
      input  freeze, flush, branch_taken, branch_target, rom_instruction,
      output rom_address, if_pc, if_instruction, if_valid, halted, fetch_count
   );

   modport master (
      output freeze, flush, branch_taken, branch_target, rom_instruction,
      input  rom_address, if_pc, if_instruction, if_valid, halted, fetch_count
   );

endinterface

// File: rtl/instruction_fetch_unit_if_id_register.sv
// IF/ID pipeline register: holds the captured PC+4, instruction word and valid flag.
//   i_clock/i_reset_n : clock, asynchronous active-low reset
//   i_hold            : keep current contents
//   i_clear           : load a bubble (wins over i_hold)
//   i_pc/i_instruction: values captured when neither hold nor clear is set
//   o_pc/o_instruction/o_valid : register contents
module if_id_register
   import instruction_fetch_unit_pkg::*;
(
   input  logic        i_clock,
   input  logic        i_reset_n,
   input  logic        i_hold,
   input  logic        i_clear,
   input  logic [31:0] i_pc,
   input  logic [31:0] i_instruction,
   output logic [31:0] o_pc,
   output logic [31:0] o_instruction,
   output logic        o_valid
);

   logic [31:0] r_pc;
   logic [31:0] r_instruction;
   logic        r_valid;

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_pc          <= '0;
         r_instruction <= NOP_WORD;
         r_valid       <= 1'b0;
      end else if (i_clear) begin
         r_pc          <= '0;
         r_instruction <= NOP_WORD;
         r_valid       <= 1'b0;
      end else if (!i_hold) begin
         r_pc          <= i_pc;
         r_instruction <= i_instruction;
         r_valid       <= 1'b1;
      end
   end

   assign o_pc          = r_pc;
   assign o_instruction = r_instruction;
   assign o_valid       = r_valid;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction-fetch stage: owns the PC, addresses the combinational instruction ROM and
// captures the returned word into the IF/ID register. Honours freeze, flush and branch
// redirect, and parks in HALT after capturing a jump-to-self.
//   i_clock    : clock, rising edge
//   i_reset_n  : asynchronous active-low reset
//   fetch_bus  : control inputs, ROM address/data, IF/ID outputs, halted, fetch_count
module instruction_fetch_unit #(
   parameter logic [31:0] RESET_PC    = 32'd0,
   parameter int unsigned BOOT_CYCLES = 2,
   parameter logic [5:0]  HALT_OPCODE = 6'b101010
) (
   input logic                     i_clock,
   input logic                     i_reset_n,
   instruction_fetch_unit_if.slave fetch_bus
);

   import instruction_fetch_unit_pkg::*;

   fetch_state_e r_state, w_state_d;
   logic [31:0]  r_pc, w_pc_d;
   logic [15:0]  r_boot_cnt, w_boot_cnt_d;
   logic [15:0]  r_count, w_count_d;

   logic [31:0]  w_pc_plus4;
   logic         w_is_halt;
   logic         w_hold;
   logic         w_clear;

   assign w_pc_plus4 = r_pc + PC_STEP;
   assign w_is_halt  = is_halt_word(fetch_bus.rom_instruction, HALT_OPCODE);

   always_comb begin
      w_state_d    = r_state;
      w_pc_d       = r_pc;
      w_boot_cnt_d = r_boot_cnt;
      w_count_d    = r_count;
      w_hold       = 1'b0;
      w_clear      = 1'b0;
      unique case (r_state)
         StBoot: begin
            // Redirects are ignored until the ROM is ready.
            w_clear = 1'b1;
            if (r_boot_cnt <= 16'd1) begin
               w_boot_cnt_d = '0;
               w_state_d    = StRun;
            end else begin
               w_boot_cnt_d = r_boot_cnt - 16'd1;
            end
         end
         StRun: begin
            if (fetch_bus.branch_taken) begin
               w_pc_d  = fetch_bus.branch_target;
               w_clear = 1'b1;
            end else if (fetch_bus.freeze) begin
               w_hold  = 1'b1;
               w_clear = fetch_bus.flush;
            end else if (fetch_bus.flush) begin
               w_pc_d  = w_pc_plus4;
               w_clear = 1'b1;
            end else begin
               w_count_d = r_count + 16'd1;
               // The halt word itself is captured; the PC parks on it.
               if (w_is_halt) begin
                  w_state_d = StHalt;
               end else begin
                  w_pc_d = w_pc_plus4;
               end
            end
         end
         StHalt: begin
            w_clear = 1'b1;
            if (fetch_bus.branch_taken) begin
               w_pc_d    = fetch_bus.branch_target;
               w_state_d = StRun;
            end
         end
         default: begin
            w_clear   = 1'b1;
            w_state_d = StBoot;
         end
      endcase
   end

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state    <= StBoot;
         r_pc       <= RESET_PC;
         r_boot_cnt <= 16'(BOOT_CYCLES);
         r_count    <= '0;
      end else begin
         r_state    <= w_state_d;
         r_pc       <= w_pc_d;
         r_boot_cnt <= w_boot_cnt_d;
         r_count    <= w_count_d;
      end
   end

   if_id_register u_if_id_register (
      .i_clock       (i_clock),
      .i_reset_n     (i_reset_n),
      .i_hold        (w_hold),
      .i_clear       (w_clear),
      .i_pc          (w_pc_plus4),
      .i_instruction (fetch_bus.rom_instruction),
      .o_pc          (fetch_bus.if_pc),
      .o_instruction (fetch_bus.if_instruction),
      .o_valid       (fetch_bus.if_valid)
   );

   assign fetch_bus.rom_address = r_pc;
   assign fetch_bus.halted      = (r_state == StHalt);
   assign fetch_bus.fetch_count = r_count;

endmodule
